// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified I/D memory arbiter.
//   arb_state_t          : arbiter FSM state encoding
//   DEFAULT_TIMEOUT_CYC  : default busy cycles allowed before a transaction is aborted
//   TIMEOUT_DATA         : read data returned when a transaction times out
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  localparam int          DEFAULT_TIMEOUT_CYC = 64;
  localparam logic [31:0] TIMEOUT_DATA        = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-side bus between the arbiter and the variable-latency memory.
//   mem_req / mem_we / mem_addr / mem_wdata : request, held stable until mem_ack
//   mem_rdata                               : read data, valid with mem_ack
//   mem_ack                                 : transaction completion
// modport master: arbiter side; modport slave: memory side.
interface mem_arbiter_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_arbiter_wait_counter.sv
// Busy-wait timer for the memory arbiter.
//   clk_i, reset_i : clock, synchronous active-high reset
//   clear_i        : arm the timer for a new transaction
//   en_i           : count one waiting cycle
//   tc_o           : high during the TIMEOUT_CYC-th waiting cycle
// Implemented as a down-counter: loaded with TIMEOUT_CYC on clear, one
// decrement per waiting cycle, so the cycle that sees 1 is the last one allowed.
module arb_wait_counter #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= CW'(TIMEOUT_CYC);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign tc_o = (cnt_q == CW'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between fetch and memory stage.
//   clk_i, reset_i             : clock, synchronous active-high reset
//   if_req_i/if_addr_i         : fetch read request and address
//   if_rdata_o/if_valid_o      : fetched word, one-cycle completion pulse
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i : data request
//   dm_rdata_o/dm_valid_o      : data read word, one-cycle completion pulse
//   mem                        : memory-side bus (master)
//   stall_if_o/stall_dm_o      : requester stalls for the hazard logic
//   err_o                      : sticky timeout flag
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction outstanding; grant data first, then fetch
// BUSY_IF | fetch read issued, waiting for ack or timeout
// BUSY_DM | data read/write issued, waiting for ack or timeout
module mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          if_req_i,
  input  logic [31:0]   if_addr_i,
  output logic [31:0]   if_rdata_o,
  output logic          if_valid_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [31:0]   dm_addr_i,
  input  logic [31:0]   dm_wdata_i,
  output logic [31:0]   dm_rdata_o,
  output logic          dm_valid_o,
  mem_arbiter_if.master mem,
  output logic          stall_if_o,
  output logic          stall_dm_o,
  output logic          err_o
);

  arb_state_t  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic        dm_valid_q, dm_valid_d;
  logic        err_q, err_d;
  logic        cnt_clear, cnt_en, cnt_tc;

  arb_wait_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .tc_o    (cnt_tc)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    err_d       = err_q;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      IDLE: begin
        // A request seen together with its own valid pulse is the one just
        // completed, so it must not be granted again.
        if (dm_req_i && !dm_valid_q) begin
          state_d     = BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          cnt_clear   = 1'b1;
        end else if (if_req_i && !if_valid_q) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          cnt_clear   = 1'b1;
        end
      end

      BUSY_IF, BUSY_DM: begin
        // An ack in the last allowed cycle still completes normally.
        if (mem.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == BUSY_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem.mem_rdata;
          end else begin
            dm_valid_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = mem.mem_rdata;
          end
        end else if (cnt_tc) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == BUSY_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = TIMEOUT_DATA;
          end else begin
            dm_valid_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = TIMEOUT_DATA;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  assign if_rdata_o = if_rdata_q;
  assign dm_rdata_o = dm_rdata_q;
  assign if_valid_o = if_valid_q;
  assign dm_valid_o = dm_valid_q;
  assign err_o      = err_q;

  assign stall_if_o = if_req_i & ~if_valid_q;
  assign stall_dm_o = dm_req_i & ~dm_valid_q;

endmodule
